counter_up_mod: RTL

- Modulo up-counter: the counting-up counterpart of the team's down-counter, used as the seconds/minutes building block of the lab clock datapath.
- Counts 0..LIMIT on enabled cycles, then either wraps with a one-cycle carry pulse (free-run) or stops and flags done (one-shot).
- Supports synchronous parallel load and start/restart under a small IDLE/RUN/DONE state machine.
- Carry output cascades into the enable of the next counter stage.

---
 rtl/counter_up_mod.sv | 61 ++++++
 1 files changed

// File: rtl/counter_up_mod.sv
// Modulo up-counter with parallel load, start/restart and an IDLE/RUN/DONE controller.
// Free-run wraps LIMIT->0 with a one-cycle carry; one-shot stops at LIMIT and flags done.
module counter_up_mod #(
    parameter int dw    = 8,
    parameter int LIMIT = 59
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ena,
    input  logic          start,
    input  logic          load,
    input  logic [dw-1:0] load_val,
    input  logic          oneshot,
    output logic [dw-1:0] result,
    output logic          carry,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [dw-1:0] LIM = dw'(LIMIT);

    state_t state;

    // Load beats start, start beats counting; carry is a pulse, so it is cleared on every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (load) begin
                result <= (load_val > LIM) ? LIM : load_val;
            end else if (start) begin
                result <= '0;
                state  <= RUN;
            end else if (state == RUN && ena) begin
                if (result == LIM) begin
                    if (oneshot) begin
                        state <= DONE;
                    end else begin
                        result <= '0;
                        carry  <= 1'b1;
                    end
                end else begin
                    result <= result + 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
